arbiter_mux2ne1: RTL and testbench

Two-requester arbiter owning the select line of a shared 2:1 datapath mux in the 16-bit CPU (e.g. instruction fetch vs. load/store sharing the single memory address port). Grants the resource to one requester at a time with round-robin fairness and holds the mux select stable for the whole ownership. Sits beside the mux and drives its select input directly; requesters may drive the shared port only while their grant is high.

---
 rtl/arbiter_mux2ne1_if.sv | 14 +
 rtl/arbiter_mux2ne1.sv | 152 +++++++++++++++
 tb/tb_arbiter_mux2ne1.sv | 157 +++++++++++++++
 3 files changed

// File: rtl/arbiter_mux2ne1_if.sv
// Request/grant/select bundle between the two requesters and the 2:1 mux arbiter.
interface arbiter_mux2ne1_if;
    logic kerkesa0;
    logic kerkesa1;
    logic leja0;
    logic leja1;
    logic Sinjali;
    logic zene;

    modport master (output kerkesa0, output kerkesa1,
                    input  leja0, input leja1, input Sinjali, input zene);
    modport slave  (input  kerkesa0, input kerkesa1,
                    output leja0, output leja1, output Sinjali, output zene);
endinterface

// File: rtl/arbiter_mux2ne1.sv
// Round-robin arbiter driving the select of a shared 2:1 mux; grants are sticky until release.
// Optional holder preemption after MAX_HOLD contended cycles is enabled by defining ARB_TIMEOUT_EN.
module arbiter_mux2ne1 #(
    parameter int MAX_HOLD = 16,
    parameter int CNT_W    = 8
) (
    input  logic               Clock,
    input  logic               Reset,
    arbiter_mux2ne1_if.slave   bus
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_G0   = 2'd1,
        ST_G1   = 2'd2
    } state_t;

    state_t r_state;
    state_t w_state_nxt;
    logic   r_last;
    logic   w_last_nxt;
    logic   r_sel;
    logic   w_sel_nxt;
    logic   r_leja0;
    logic   r_leja1;
    logic   r_zene;
    logic   w_preempt;

    // Parameter legality is resolved at elaboration so an illegal build never produces a netlist.
    if ((MAX_HOLD < 2) || (MAX_HOLD > 255) || ((64'd1 << CNT_W) <= 64'(MAX_HOLD))) begin : g_bad_param
        $error("arbiter_mux2ne1: illegal MAX_HOLD/CNT_W combination");
    end

`ifdef ARB_TIMEOUT_EN
    logic [CNT_W-1:0] r_hold_cnt;
    logic             w_other_req;

    // The waiting side's request decides whether the holder is accruing contended time.
    always_comb begin
        w_other_req = 1'b0;
        case (r_state)
            ST_G0:   w_other_req = bus.kerkesa1;
            ST_G1:   w_other_req = bus.kerkesa0;
            default: w_other_req = 1'b0;
        endcase
        if (w_other_req && (r_hold_cnt == CNT_W'(MAX_HOLD - 1))) begin
            w_preempt = 1'b1;
        end else begin
            w_preempt = 1'b0;
        end
    end

    // Hold counter: clears on each new grant, advances only while the other side waits.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            r_hold_cnt <= {CNT_W{1'b0}};
        end else if ((w_state_nxt != r_state) && (w_state_nxt != ST_IDLE)) begin
            r_hold_cnt <= {CNT_W{1'b0}};
        end else if (w_other_req) begin
            r_hold_cnt <= r_hold_cnt + CNT_W'(1);
        end else begin
            r_hold_cnt <= r_hold_cnt;
        end
    end
`else
    // Without preemption the holder keeps the resource until it releases.
    always_comb begin
        w_preempt = 1'b0;
    end
`endif

    // Next-state, priority pointer and mux select decode.
    always_comb begin
        w_state_nxt = r_state;
        w_last_nxt  = r_last;
        w_sel_nxt   = r_sel;
        case (r_state)
            ST_IDLE: begin
                if (bus.kerkesa0 && bus.kerkesa1) begin
                    w_state_nxt = r_last ? ST_G0 : ST_G1;
                end else if (bus.kerkesa0) begin
                    w_state_nxt = ST_G0;
                end else if (bus.kerkesa1) begin
                    w_state_nxt = ST_G1;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_G0: begin
                if (bus.kerkesa0 && !w_preempt) begin
                    w_state_nxt = ST_G0;
                end else if (bus.kerkesa1) begin
                    w_state_nxt = ST_G1;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_G1: begin
                if (bus.kerkesa1 && !w_preempt) begin
                    w_state_nxt = ST_G1;
                end else if (bus.kerkesa0) begin
                    w_state_nxt = ST_G0;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
        // Select and pointer only move on a grant; IDLE keeps the mux where it was.
        case (w_state_nxt)
            ST_G0: begin
                w_last_nxt = 1'b0;
                w_sel_nxt  = 1'b0;
            end
            ST_G1: begin
                w_last_nxt = 1'b1;
                w_sel_nxt  = 1'b1;
            end
            default: begin
                w_last_nxt = r_last;
                w_sel_nxt  = r_sel;
            end
        endcase
    end

    // State and registered outputs, all decoded from the next state.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            r_state <= ST_IDLE;
            r_last  <= 1'b1;
            r_sel   <= 1'b0;
            r_leja0 <= 1'b0;
            r_leja1 <= 1'b0;
            r_zene  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_last  <= w_last_nxt;
            r_sel   <= w_sel_nxt;
            r_leja0 <= (w_state_nxt == ST_G0);
            r_leja1 <= (w_state_nxt == ST_G1);
            r_zene  <= (w_state_nxt != ST_IDLE);
        end
    end

    assign bus.leja0   = r_leja0;
    assign bus.leja1   = r_leja1;
    assign bus.Sinjali = r_sel;
    assign bus.zene    = r_zene;

endmodule

// File: tb/tb_arbiter_mux2ne1.sv
// Directed bench for arbiter_mux2ne1; the timeout scenario follows ARB_TIMEOUT_EN.
module tb_arbiter_mux2ne1;

    logic Clock;
    logic Reset;
    int   checks;
    int   errors;

    arbiter_mux2ne1_if bus ();

    arbiter_mux2ne1 #(.MAX_HOLD(16), .CNT_W(8)) dut (
        .Clock (Clock),
        .Reset (Reset),
        .bus   (bus.slave)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    task automatic tick();
        @(posedge Clock);
        #1;
    endtask

    task automatic test_reset();
        Reset = 1'b1; bus.kerkesa0 = 1'b1; bus.kerkesa1 = 1'b1;
        tick(); tick();
        checks++; if (bus.leja0 !== 1'b0) begin errors++; $display("FAIL reset_leja0 got=%b exp=0", bus.leja0); end
        checks++; if (bus.leja1 !== 1'b0) begin errors++; $display("FAIL reset_leja1 got=%b exp=0", bus.leja1); end
        checks++; if (bus.zene !== 1'b0) begin errors++; $display("FAIL reset_zene got=%b exp=0", bus.zene); end
        checks++; if (bus.Sinjali !== 1'b0) begin errors++; $display("FAIL reset_sel got=%b exp=0", bus.Sinjali); end
        Reset = 1'b0;
        tick();
        checks++; if (bus.leja0 !== 1'b1 || bus.leja1 !== 1'b0) begin errors++; $display("FAIL reset_first_tie got=%b%b exp=10", bus.leja0, bus.leja1); end
        checks++; if (bus.Sinjali !== 1'b0) begin errors++; $display("FAIL reset_first_sel got=%b exp=0", bus.Sinjali); end
        bus.kerkesa0 = 1'b0; bus.kerkesa1 = 1'b0;
        tick();
        checks++; if (bus.zene !== 1'b0) begin errors++; $display("FAIL reset_idle_zene got=%b exp=0", bus.zene); end
    endtask

    task automatic test_single();
        bus.kerkesa1 = 1'b1;
        #1;
        checks++; if (bus.leja1 !== 1'b0) begin errors++; $display("FAIL single_latency got=%b exp=0", bus.leja1); end
        for (int i = 0; i < 5; i++) begin
            tick();
            checks++; if (bus.leja1 !== 1'b1 || bus.Sinjali !== 1'b1 || bus.zene !== 1'b1) begin
                errors++; $display("FAIL single_hold cyc=%0d leja1=%b sel=%b zene=%b exp=111", i, bus.leja1, bus.Sinjali, bus.zene);
            end
        end
        bus.kerkesa1 = 1'b0;
        tick();
        checks++; if (bus.leja1 !== 1'b0 || bus.zene !== 1'b0) begin errors++; $display("FAIL single_release leja1=%b zene=%b exp=00", bus.leja1, bus.zene); end
        checks++; if (bus.Sinjali !== 1'b1) begin errors++; $display("FAIL single_sel_held got=%b exp=1", bus.Sinjali); end
    endtask

    task automatic test_handover();
        bus.kerkesa0 = 1'b1;
        tick();
        checks++; if (bus.leja0 !== 1'b1 || bus.Sinjali !== 1'b0) begin errors++; $display("FAIL handover_g0 leja0=%b sel=%b exp=10", bus.leja0, bus.Sinjali); end
        bus.kerkesa1 = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            checks++; if (bus.leja0 !== 1'b1 || bus.leja1 !== 1'b0) begin errors++; $display("FAIL handover_sticky cyc=%0d got=%b%b exp=10", i, bus.leja0, bus.leja1); end
        end
        bus.kerkesa0 = 1'b0;
        tick();
        checks++; if (bus.leja0 !== 1'b0 || bus.leja1 !== 1'b1) begin errors++; $display("FAIL handover_grants got=%b%b exp=01", bus.leja0, bus.leja1); end
        checks++; if (bus.zene !== 1'b1 || bus.Sinjali !== 1'b1) begin errors++; $display("FAIL handover_zene_sel zene=%b sel=%b exp=11", bus.zene, bus.Sinjali); end
        bus.kerkesa1 = 1'b0;
        tick();
        checks++; if (bus.zene !== 1'b0 || bus.leja1 !== 1'b0) begin errors++; $display("FAIL handover_idle zene=%b leja1=%b exp=00", bus.zene, bus.leja1); end
    endtask

    task automatic test_round_robin();
        bus.kerkesa0 = 1'b1; bus.kerkesa1 = 1'b1;
        tick();
        checks++; if (bus.leja0 !== 1'b1 || bus.leja1 !== 1'b0) begin errors++; $display("FAIL rr_first got=%b%b exp=10", bus.leja0, bus.leja1); end
        bus.kerkesa0 = 1'b0; bus.kerkesa1 = 1'b0;
        tick();
        checks++; if (bus.zene !== 1'b0) begin errors++; $display("FAIL rr_gap zene=%b exp=0", bus.zene); end
        bus.kerkesa0 = 1'b1; bus.kerkesa1 = 1'b1;
        tick();
        checks++; if (bus.leja0 !== 1'b0 || bus.leja1 !== 1'b1 || bus.Sinjali !== 1'b1) begin
            errors++; $display("FAIL rr_second got=%b%b sel=%b exp=01 sel=1", bus.leja0, bus.leja1, bus.Sinjali);
        end
        bus.kerkesa0 = 1'b0; bus.kerkesa1 = 1'b0;
        tick();
    endtask

    task automatic test_timeout();
        bus.kerkesa0 = 1'b1;
        tick(); tick(); tick();
        checks++; if (bus.leja0 !== 1'b1) begin errors++; $display("FAIL timeout_g0 got=%b exp=1", bus.leja0); end
        bus.kerkesa1 = 1'b1;
`ifdef ARB_TIMEOUT_EN
        for (int i = 1; i <= 15; i++) begin
            tick();
            checks++; if (bus.leja0 !== 1'b1 || bus.leja1 !== 1'b0) begin errors++; $display("FAIL timeout_early cyc=%0d got=%b%b exp=10", i, bus.leja0, bus.leja1); end
        end
        tick();
        checks++; if (bus.leja0 !== 1'b0 || bus.leja1 !== 1'b1 || bus.Sinjali !== 1'b1) begin
            errors++; $display("FAIL timeout_handover got=%b%b sel=%b exp=01 sel=1", bus.leja0, bus.leja1, bus.Sinjali);
        end
        bus.kerkesa1 = 1'b0;
        tick();
        checks++; if (bus.leja0 !== 1'b1 || bus.leja1 !== 1'b0) begin errors++; $display("FAIL timeout_regrant got=%b%b exp=10", bus.leja0, bus.leja1); end
        bus.kerkesa0 = 1'b0;
`else
        for (int i = 1; i <= 40; i++) begin
            tick();
            checks++; if (bus.leja0 !== 1'b1 || bus.leja1 !== 1'b0) begin errors++; $display("FAIL notimeout_hold cyc=%0d got=%b%b exp=10", i, bus.leja0, bus.leja1); end
        end
        bus.kerkesa0 = 1'b0;
        tick();
        checks++; if (bus.leja1 !== 1'b1 || bus.leja0 !== 1'b0) begin errors++; $display("FAIL notimeout_release got=%b%b exp=01", bus.leja0, bus.leja1); end
        bus.kerkesa1 = 1'b0;
`endif
        tick();
        checks++; if (bus.zene !== 1'b0) begin errors++; $display("FAIL timeout_idle zene=%b exp=0", bus.zene); end
    endtask

    task automatic test_reset_mid();
        bus.kerkesa1 = 1'b1;
        tick();
        checks++; if (bus.leja1 !== 1'b1) begin errors++; $display("FAIL midrst_g1 got=%b exp=1", bus.leja1); end
        Reset = 1'b1;
        tick();
        checks++; if (bus.leja1 !== 1'b0 || bus.Sinjali !== 1'b0 || bus.zene !== 1'b0) begin
            errors++; $display("FAIL midrst_drop leja1=%b sel=%b zene=%b exp=000", bus.leja1, bus.Sinjali, bus.zene);
        end
        tick();
        checks++; if (bus.leja1 !== 1'b0) begin errors++; $display("FAIL midrst_ignore got=%b exp=0", bus.leja1); end
        Reset = 1'b0;
        tick();
        checks++; if (bus.leja1 !== 1'b1 || bus.Sinjali !== 1'b1) begin errors++; $display("FAIL midrst_regrant leja1=%b sel=%b exp=11", bus.leja1, bus.Sinjali); end
        bus.kerkesa1 = 1'b0;
        tick();
    endtask

    initial begin
        checks = 0;
        errors = 0;
        Reset = 1'b1;
        bus.kerkesa0 = 1'b0;
        bus.kerkesa1 = 1'b0;
        test_reset();
        test_single();
        test_handover();
        test_round_robin();
        test_timeout();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
